keypad_scanner: RTL and testbench

- Matrix-keypad input scanner: the reading counterpart of the SoC's multiplexed 7-segment display driver.
- Drives one keypad row low at a time and samples the column lines on that row.
- Debounces a single pressed key and queues key events in a small FIFO with a valid/ready pop interface and a level interrupt.
- Sits beside gpio_top; a bus wrapper or the core's PLIC irq source consumes its outputs.

---
 rtl/keypad_scanner.sv | 252 +++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Purpose : matrix-keypad scanner; drives one row low at a time, debounces a single key, queues events.
// Latency : a press stable at a row-sample edge appears on key_valid_o about 2 + DEBOUNCE_CYC + 1 cycles later.
// Backpressure: key_valid_o/key_ready_i pop; a full FIFO drops new events and sets sticky overflow_o.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   row_o         active-low row drive, at most one bit low (all ones in reset)
//   col_i         active-low asynchronous column sense, pulled up externally
//   key_valid_o   FIFO non-empty; key_code_o holds the head event
//   key_code_o    {release, 1'b0, row*COLS+col}, zero when the FIFO is empty
//   key_ready_i   pops the head when key_valid_o is also high
//   clr_ovf_i     clears overflow_o (a same-cycle drop wins)
//   overflow_o    sticky: an event was dropped on a full FIFO
//   key_irq_o     level interrupt, same as key_valid_o
//
// Build option: define KEYPAD_RELEASE_EVT_EN to also queue a release event
// (bit 7 set) when a held key is debounced as released.

module keypad_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 8,
  parameter int DEBOUNCE_CYC = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row_o,
  input  logic [COLS-1:0] col_i,
  output logic            key_valid_o,
  output logic [7:0]      key_code_o,
  input  logic            key_ready_i,
  input  logic            clr_ovf_i,
  output logic            overflow_o,
  output logic            key_irq_o
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE_CYC);
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Column synchronizer; resets to the idle (pulled-up) level.
  // ---------------------------------------------------------------------------
  logic [COLS-1:0] col_meta;
  logic [COLS-1:0] col_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_s    <= '1;
    end else begin
      col_meta <= col_i;
      col_s    <= col_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan / debounce state
  // ---------------------------------------------------------------------------
  state_t          state_q,  state_d;
  logic            started_q;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [DBW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [CW-1:0]   lat_col_q, lat_col_d;

  logic            evt_vld;
  logic [7:0]      evt_dat;

  logic            any_low;
  logic [CW-1:0]   first_col;
  logic            lat_low;
  logic [RW-1:0]   row_next;
  logic [5:0]      code;

  // Lowest-index active column; scanning downward lets the lowest index win.
  always_comb begin
    any_low   = 1'b0;
    first_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_s[c]) begin
        any_low   = 1'b1;
        first_col = CW'(c);
      end
    end
  end

  assign lat_low  = ~col_s[lat_col_q];
  assign row_next = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + RW'(1);
  // The row index is frozen outside SCAN, so it is the latched row.
  assign code     = 6'(row_idx_q) * 6'(COLS) + 6'(lat_col_q);

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    div_cnt_d = div_cnt_q;
    deb_cnt_d = deb_cnt_q;
    lat_col_d = lat_col_q;
    evt_vld   = 1'b0;
    evt_dat   = '0;

    case (state_q)
      ST_SCAN: begin
        // Nothing moves until the first row has actually been driven.
        if (started_q) begin
          if (div_cnt_q == DIV_LAST) begin
            if (any_low) begin
              state_d   = ST_DEBOUNCE;
              lat_col_d = first_col;
              deb_cnt_d = '0;
            end else begin
              row_idx_d = row_next;
              div_cnt_d = '0;
            end
          end else begin
            div_cnt_d = div_cnt_q + DW'(1);
          end
        end
      end

      ST_DEBOUNCE: begin
        if (lat_low) begin
          if (deb_cnt_q == DEB_LAST) begin
            evt_vld   = 1'b1;
            evt_dat   = {2'b00, code};
            state_d   = ST_HOLD;
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + DBW'(1);
          end
        end else begin
          // Bounce: abandon this key and continue with a fresh period on the next row.
          state_d   = ST_SCAN;
          row_idx_d = row_next;
          div_cnt_d = '0;
          deb_cnt_d = '0;
        end
      end

      ST_HOLD: begin
        // Only the latched key is watched; other keys are ignored until release.
        if (!lat_low) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d   = ST_SCAN;
            row_idx_d = row_next;
            div_cnt_d = '0;
            deb_cnt_d = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
            evt_vld   = 1'b1;
            evt_dat   = {2'b10, code};
`endif
          end else begin
            deb_cnt_d = deb_cnt_q + DBW'(1);
          end
        end else begin
          deb_cnt_d = '0;
        end
      end

      default: begin
        state_d   = ST_SCAN;
        div_cnt_d = '0;
        deb_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SCAN;
      started_q <= 1'b0;
      row_idx_q <= '0;
      div_cnt_q <= '0;
      deb_cnt_q <= '0;
      lat_col_q <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      row_idx_q <= row_idx_d;
      div_cnt_q <= div_cnt_d;
      deb_cnt_q <= deb_cnt_d;
      lat_col_q <= lat_col_d;
    end
  end

  assign row_o = started_q ? ~(ROWS'(1) << row_idx_q) : '1;

  // ---------------------------------------------------------------------------
  // Event FIFO. Pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        fifo_empty;
  logic        fifo_full;
  logic        do_pop;
  logic        do_push;
  logic        drop;
  logic        ovf_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop     = ~fifo_empty & key_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign do_push    = evt_vld & (~fifo_full | do_pop);
  assign drop       = evt_vld & fifo_full & ~do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_q[AW-1:0]] <= evt_dat;
  end

  // Drop wins over a same-cycle clear so no loss goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign key_valid_o = ~fifo_empty;
  assign key_irq_o   = ~fifo_empty;
  assign key_code_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q[AW-1:0]];
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad model on row_o/col_i, expected
// events queued when keys are pressed and compared as the DUT FIFO is popped.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_o;
  logic [3:0] col_i;
  logic       key_valid_o;
  logic [7:0] key_code_o;
  logic       key_ready_i;
  logic       clr_ovf_i;
  logic       overflow_o;
  logic       key_irq_o;

  // One-key keypad model: the pressed key pulls its column low only while its row is driven.
  logic       key_down;
  logic [1:0] key_row;
  logic [1:0] key_col;
  logic [3:0] col_pat;

  assign col_pat = ~(4'b0001 << key_col);
  assign col_i   = (key_down && !row_o[key_row]) ? col_pat : 4'hF;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE_CYC(16), .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_o       (row_o),
    .col_i       (col_i),
    .key_valid_o (key_valid_o),
    .key_code_o  (key_code_o),
    .key_ready_i (key_ready_i),
    .clr_ovf_i   (clr_ovf_i),
    .overflow_o  (overflow_o),
    .key_irq_o   (key_irq_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Four-entry FIFO expectation: a push beyond capacity is a drop.
  task automatic model_push(input logic [7:0] code);
    if (exp_q.size() < 4) exp_q.push_back(code);
    else exp_ovf = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!key_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {7'd0, key_valid_o}, 8'h01);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check({tag, "_vld"}, {7'd0, key_valid_o}, 8'h01);
    check(tag, key_code_o, e);
    key_ready_i = 1'b1;
    @(negedge clk);
    key_ready_i = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_vld"},  {7'd0, key_valid_o}, 8'h00);
    check({tag, "_irq"},  {7'd0, key_irq_o},   8'h00);
    check({tag, "_code"}, key_code_o,          8'h00);
  endtask

  initial begin
    logic [3:0] exp_row;
    logic [1:0] rows [5];
    logic [1:0] cols [5];
    int         n;

    rows = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    cols = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};

    rst_n       = 1'b0;
    key_down    = 1'b0;
    key_row     = 2'd2;
    key_col     = 2'd1;
    key_ready_i = 1'b0;
    clr_ovf_i   = 1'b0;
    exp_ovf     = 1'b0;

    // Power-on reset state
    repeat (3) @(negedge clk);
    check("por_row", {4'h0, row_o}, 8'h0F);
    check_empty("por");
    check("por_ovf", {7'd0, overflow_o}, 8'h00);
    rst_n = 1'b1;

    // 1. Reset asserted while a key is held in HOLD
    key_down = 1'b1;
    model_push(8'h09);
    wait_valid("t1_press_vld");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t1_rst_row", {4'h0, row_o}, 8'h0F);
    check_empty("t1_rst");
    check("t1_rst_ovf", {7'd0, overflow_o}, 8'h00);
    key_down = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((i / 8) % 4));
      check("t1_row_seq", {4'h0, row_o}, {4'h0, exp_row});
    end

    // 2. Long press of row 2 col 1, no consumer
    key_row  = 2'd2;
    key_col  = 2'd1;
    key_down = 1'b1;
    model_push(8'h09);
    wait_valid("t2_vld");
    check("t2_irq", {7'd0, key_irq_o}, 8'h01);
    check("t2_code", key_code_o, 8'h09);
    repeat (60) @(negedge clk);
    check("t2_hold_row", {4'h0, row_o}, 8'h0B);
    key_down = 1'b0;
    repeat (17) @(negedge clk);
    check("t2_rel_row_frozen", {4'h0, row_o}, 8'h0B);
    @(negedge clk);
    check("t2_rel_row_next", {4'h0, row_o}, 8'h07);
`ifdef KEYPAD_RELEASE_EVT_EN
    model_push(8'h89);
`endif
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) pop_check("t2_pop");
    check_empty("t2_drained");

    // 3. Bounce on row 2 col 1: debounce entered, then abandoned
    n = 0;
    while (row_o != 4'hB && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t3_row2_reached", {4'h0, row_o}, 8'h0B);
    key_down = 1'b1;
    repeat (10) @(negedge clk);
    check("t3_row_frozen", {4'h0, row_o}, 8'h0B);
    key_down = 1'b0;
    n = 0;
    while (row_o == 4'hB && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t3_resume_row", {4'h0, row_o}, 8'h07);
    check("t3_no_event", {7'd0, key_valid_o}, 8'h00);
    repeat (40) @(negedge clk);
    check("t3_still_no_event", {7'd0, key_valid_o}, 8'h00);

    // 4. Five presses into a four-entry FIFO
    for (int k = 0; k < 5; k++) begin
      key_row  = rows[k];
      key_col  = cols[k];
      key_down = 1'b1;
      model_push({4'h0, rows[k], cols[k]});
      repeat (60) @(negedge clk);
      key_down = 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
      model_push({4'h8, rows[k], cols[k]});
`endif
      repeat (30) @(negedge clk);
      check("t4_ovf", {7'd0, overflow_o}, {7'd0, exp_ovf});
    end
    check("t4_vld", {7'd0, key_valid_o}, 8'h01);
    clr_ovf_i = 1'b1;
    @(negedge clk);
    clr_ovf_i = 1'b0;
    exp_ovf   = 1'b0;
    check("t4_ovf_cleared", {7'd0, overflow_o}, 8'h00);

    // 5. Drain; each pop exposes the next head the following cycle
    while (exp_q.size() > 0) pop_check("t5_pop");
    check_empty("t5_drained");
    check("t5_ovf", {7'd0, overflow_o}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
